// File: rtl/uart_pkg.sv
// Shared types and helpers for the frame receive path.
package uart_pkg;

    typedef enum logic [2:0] {
        HUNT,
        LEN,
        PAYLOAD,
        CHK,
        HOLD
    } frm_state_t;

    localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

    // Running 8-bit additive checksum (wraps mod 256).
    function automatic logic [7:0] frm_chk(input logic [7:0] sum, input logic [7:0] b);
        return sum + b;
    endfunction

endpackage

// File: rtl/uart_frame_rx_if.sv
// Byte-in / frame-out signal bundle of the frame receiver.
interface uart_frame_rx_if #(
    parameter int unsigned MAX_LEN = 16
);
    localparam int unsigned AW = $clog2(MAX_LEN);
    localparam int unsigned LW = $clog2(MAX_LEN + 1);

    logic [7:0]    rx_data;
    logic          rx_done;
    logic          frm_ack;
    logic [AW-1:0] rd_addr;
    logic [7:0]    rd_data;
    logic          frm_valid;
    logic [LW-1:0] frm_len;
    logic          err_len;
    logic          err_chk;
    logic          err_tout;
    logic [7:0]    drop_cnt;
    logic          busy;

    // Upstream receiver plus consumer side.
    modport master (
        output rx_data, rx_done, frm_ack, rd_addr,
        input  rd_data, frm_valid, frm_len, err_len, err_chk, err_tout, drop_cnt, busy
    );

    // Frame receiver side.
    modport slave (
        input  rx_data, rx_done, frm_ack, rd_addr,
        output rd_data, frm_valid, frm_len, err_len, err_chk, err_tout, drop_cnt, busy
    );

endinterface

// File: rtl/frm_buf.sv
// Payload buffer: simple dual-port RAM, one write port, one registered read port.
module frm_buf #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [7:0]    wr_data_i,
    input  logic [AW-1:0] rd_addr_i,
    output logic [7:0]    rd_data_o
);

    logic [7:0] mem_q [DEPTH];
    logic [7:0] rd_data_q;

    // Write port; contents intentionally survive reset, frm_valid qualifies them.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Registered read port (read-before-write), cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/uart_frame_rx.sv
// Frame receive controller: sync hunt, length, payload, checksum, hold for consumer.
module uart_frame_rx
    import uart_pkg::*;
#(
    parameter logic [7:0]  SYNC_BYTE = SYNC_DEFAULT,
    parameter int unsigned MAX_LEN   = 16,
    parameter int unsigned TIMEOUT   = 104160
) (
    input logic            clk,
    input logic            rst,
    uart_frame_rx_if.slave bus_io
);

    localparam int unsigned AW = $clog2(MAX_LEN);
    localparam int unsigned LW = $clog2(MAX_LEN + 1);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TCNT_TERM = TW'(TIMEOUT - 1);

    frm_state_t    state_q;
    logic          rx_done_q;
    logic [LW-1:0] len_q;
    logic [LW-1:0] idx_q;
    logic [7:0]    sum_q;
    logic [TW-1:0] tcnt_q;
    logic          frm_valid_q;
    logic [LW-1:0] frm_len_q;
    logic          err_len_q;
    logic          err_chk_q;
    logic          err_tout_q;
    logic [7:0]    drop_cnt_q;

    logic stb;
    logic busy;
    logic len_bad;

    assign stb     = bus_io.rx_done & ~rx_done_q;
    assign busy    = (state_q == LEN) || (state_q == PAYLOAD) || (state_q == CHK);
    assign len_bad = (bus_io.rx_data == 8'd0) || (32'(bus_io.rx_data) > MAX_LEN);

    // Frame FSM with inter-byte timeout and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= HUNT;
            rx_done_q   <= 1'b0;
            len_q       <= '0;
            idx_q       <= '0;
            sum_q       <= '0;
            tcnt_q      <= '0;
            frm_valid_q <= 1'b0;
            frm_len_q   <= '0;
            err_len_q   <= 1'b0;
            err_chk_q   <= 1'b0;
            err_tout_q  <= 1'b0;
            drop_cnt_q  <= '0;
        end else begin
            rx_done_q  <= bus_io.rx_done;
            err_len_q  <= 1'b0;
            err_chk_q  <= 1'b0;
            err_tout_q <= 1'b0;

            // Timeout only runs between bytes inside a frame; a byte always wins.
            if (busy && !stb) begin
                if (tcnt_q == TCNT_TERM) begin
                    tcnt_q     <= '0;
                    err_tout_q <= 1'b1;
                    state_q    <= HUNT;
                end else begin
                    tcnt_q <= tcnt_q + 1'b1;
                end
            end else begin
                tcnt_q <= '0;
            end

            case (state_q)
                HUNT: begin
                    if (stb && bus_io.rx_data == SYNC_BYTE) begin
                        state_q <= LEN;
                    end
                end
                LEN: begin
                    if (stb) begin
                        if (len_bad) begin
                            err_len_q <= 1'b1;
                            state_q   <= HUNT;
                        end else begin
                            len_q   <= bus_io.rx_data[LW-1:0];
                            idx_q   <= '0;
                            sum_q   <= bus_io.rx_data;
                            state_q <= PAYLOAD;
                        end
                    end
                end
                PAYLOAD: begin
                    if (stb) begin
                        sum_q <= frm_chk(sum_q, bus_io.rx_data);
                        idx_q <= idx_q + 1'b1;
                        if (idx_q == len_q - 1'b1) begin
                            state_q <= CHK;
                        end
                    end
                end
                CHK: begin
                    if (stb) begin
                        if (bus_io.rx_data == sum_q) begin
                            frm_valid_q <= 1'b1;
                            frm_len_q   <= len_q;
                            state_q     <= HOLD;
                        end else begin
                            err_chk_q <= 1'b1;
                            state_q   <= HUNT;
                        end
                    end
                end
                HOLD: begin
                    if (stb && drop_cnt_q != 8'hFF) begin
                        drop_cnt_q <= drop_cnt_q + 1'b1;
                    end
                    if (bus_io.frm_ack) begin
                        frm_valid_q <= 1'b0;
                        state_q     <= HUNT;
                    end
                end
                default: state_q <= HUNT;
            endcase
        end
    end

    frm_buf #(
        .DEPTH (MAX_LEN),
        .AW    (AW)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (stb && state_q == PAYLOAD),
        .wr_addr_i (idx_q[AW-1:0]),
        .wr_data_i (bus_io.rx_data),
        .rd_addr_i (bus_io.rd_addr),
        .rd_data_o (bus_io.rd_data)
    );

    assign bus_io.frm_valid = frm_valid_q;
    assign bus_io.frm_len   = frm_len_q;
    assign bus_io.err_len   = err_len_q;
    assign bus_io.err_chk   = err_chk_q;
    assign bus_io.err_tout  = err_tout_q;
    assign bus_io.drop_cnt  = drop_cnt_q;
    assign bus_io.busy      = busy;

endmodule
